// File: rtl/checksum_frame_checker.sv
// Serial frame-integrity checker: N_WORDS LSB-first data words plus one checksum word,
// folded with a one's-complement, two's-complement or XOR checksum selected by MODE.
module checksum_frame_checker #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned N_WORDS = 8,
    parameter int unsigned MODE    = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              data_i,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ok_o,
    output logic              err_o,
    output logic [WORD_W-1:0] sum_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int unsigned BitCntW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned WordCntW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [BitCntW-1:0]  LastBit  = BitCntW'(WORD_W - 1);
    localparam logic [WordCntW-1:0] LastWord = WordCntW'(N_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCsum
    } state_e;

    state_e               r_state, w_state_nxt;
    logic [BitCntW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [WordCntW-1:0]  r_word_cnt, w_word_cnt_nxt;
    logic [WORD_W-1:0]    r_shift, w_shift_in;
    logic [WORD_W-1:0]    r_acc, w_acc_nxt, w_acc_fold;
    logic [WORD_W-1:0]    w_expected;
    logic [WORD_W-1:0]    r_sum, w_sum_nxt;
    logic [WORD_W:0]      w_add;
    logic [CNT_W-1:0]     r_err_cnt, w_err_cnt_nxt;
    logic                 r_busy, r_done, r_ok, r_err;
    logic                 w_done_nxt, w_ok_nxt, w_err_nxt;
    logic                 w_sample, w_word_end;

    // clear_i wins over en_i: the bit presented with a clear is dropped.
    assign w_sample   = en_i & ~clear_i;
    assign w_word_end = w_sample & (r_bit_cnt == LastBit);
    assign w_shift_in = {data_i, r_shift[WORD_W-1:1]};
    assign w_add      = {1'b0, r_acc} + {1'b0, w_shift_in};

    always_comb begin
        w_acc_fold = r_acc ^ w_shift_in;
        w_expected = r_acc;
        if (MODE == 0) begin
            // End-around carry; cannot overflow again since a carry leaves at most 2^W-2.
            w_acc_fold = w_add[WORD_W-1:0] + WORD_W'(w_add[WORD_W]);
            w_expected = ~r_acc;
        end else if (MODE == 1) begin
            w_acc_fold = w_add[WORD_W-1:0];
            w_expected = ~r_acc + WORD_W'(1);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_word_cnt_nxt = r_word_cnt;
        w_acc_nxt      = r_acc;
        w_sum_nxt      = r_sum;
        w_err_cnt_nxt  = r_err_cnt;
        w_done_nxt     = 1'b0;
        w_ok_nxt       = 1'b0;
        w_err_nxt      = 1'b0;

        unique case (r_state)
            StIdle, StData: begin
                if (w_sample) begin
                    w_state_nxt   = StData;
                    w_bit_cnt_nxt = r_bit_cnt + BitCntW'(1);
                    if (w_word_end) begin
                        w_bit_cnt_nxt = '0;
                        w_acc_nxt     = w_acc_fold;
                        if (r_word_cnt == LastWord) begin
                            w_state_nxt    = StCsum;
                            w_word_cnt_nxt = '0;
                        end else begin
                            w_word_cnt_nxt = r_word_cnt + WordCntW'(1);
                        end
                    end
                end
            end
            StCsum: begin
                if (w_sample) begin
                    w_bit_cnt_nxt = r_bit_cnt + BitCntW'(1);
                    if (w_word_end) begin
                        w_state_nxt   = StIdle;
                        w_bit_cnt_nxt = '0;
                        w_acc_nxt     = '0;
                        w_done_nxt    = 1'b1;
                        w_ok_nxt      = (w_shift_in == w_expected);
                        w_err_nxt     = (w_shift_in != w_expected);
                        w_sum_nxt     = w_expected;
                        if ((w_shift_in != w_expected) && (r_err_cnt != '1)) begin
                            w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        if (clear_i) begin
            w_state_nxt    = StIdle;
            w_bit_cnt_nxt  = '0;
            w_word_cnt_nxt = '0;
            w_acc_nxt      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= StIdle;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_err_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            if (w_sample) begin
                r_shift <= w_shift_in;
            end
            r_acc      <= w_acc_nxt;
            r_sum      <= w_sum_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_busy     <= (w_state_nxt != StIdle);
            r_done     <= w_done_nxt;
            r_ok       <= w_ok_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign ok_o      = r_ok;
    assign err_o     = r_err;
    assign sum_o     = r_sum;
    assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_checksum_frame_checker.sv
// Randomised bench: four checkers (MODE 0/1/2 and a 2-bit-counter MODE 0) share one serial
// stream; a frame-level reference model predicts every output each cycle.
module tb_checksum_frame_checker;

    localparam int unsigned WORD_W     = 8;
    localparam int unsigned N_WORDS    = 8;
    localparam int unsigned FRAME_BITS = (N_WORDS + 1) * WORD_W;

    logic clk = 1'b0;
    logic rst_n, en, din, clr;

    logic [3:0]        busy, done, ok, err;
    logic [WORD_W-1:0] sum [4];
    logic [15:0]       cnt [3];
    logic [1:0]        cnt3;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        checksum_frame_checker #(
            .WORD_W (WORD_W),
            .N_WORDS(N_WORDS),
            .MODE   (g),
            .CNT_W  (16)
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst_n),
            .en_i     (en),
            .data_i   (din),
            .clear_i  (clr),
            .busy_o   (busy[g]),
            .done_o   (done[g]),
            .ok_o     (ok[g]),
            .err_o    (err[g]),
            .sum_o    (sum[g]),
            .err_cnt_o(cnt[g])
        );
    end

    checksum_frame_checker #(
        .WORD_W (WORD_W),
        .N_WORDS(N_WORDS),
        .MODE   (0),
        .CNT_W  (2)
    ) u_dut_sat (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .en_i     (en),
        .data_i   (din),
        .clear_i  (clr),
        .busy_o   (busy[3]),
        .done_o   (done[3]),
        .ok_o     (ok[3]),
        .err_o    (err[3]),
        .sum_o    (sum[3]),
        .err_cnt_o(cnt3)
    );

    always #5 clk = ~clk;

    longint cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit                m_bits[$];
    logic              exp_done;
    logic [3:0]        m_ok;
    logic [WORD_W-1:0] m_sum [4];
    int unsigned       m_cnt [4];
    logic [WORD_W-1:0] ck_words [N_WORDS];

    logic [WORD_W-1:0] f_words [N_WORDS];
    logic [WORD_W-1:0] f_csum;
    int                ok0_seen = 0;
    longint            done_t[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int mode_of(input int i);
        return (i == 3) ? 0 : i;
    endfunction

    function automatic int unsigned cmax_of(input int i);
        return (i == 3) ? 3 : 65535;
    endfunction

    // Checksum straight from the arithmetic definitions, computed over ck_words.
    function automatic logic [WORD_W-1:0] ref_ck(input int mode);
        int unsigned       s = 0;
        logic [WORD_W-1:0] x = '0;
        int unsigned       mask = (1 << WORD_W) - 1;
        for (int k = 0; k < N_WORDS; k++) begin
            s += ck_words[k];
            x ^= ck_words[k];
        end
        if (mode == 0) begin
            while (s > mask) s = (s & mask) + (s >> WORD_W);
            return ~WORD_W'(s);
        end else if (mode == 1) begin
            return WORD_W'(0 - s);
        end
        return x;
    endfunction

    task automatic model_frame();
        logic [WORD_W-1:0] rx;
        logic [WORD_W-1:0] e;
        for (int k = 0; k < N_WORDS; k++)
            for (int j = 0; j < WORD_W; j++) ck_words[k][j] = m_bits[k * WORD_W + j];
        for (int j = 0; j < WORD_W; j++) rx[j] = m_bits[N_WORDS * WORD_W + j];
        for (int i = 0; i < 4; i++) begin
            e        = ref_ck(mode_of(i));
            m_ok[i]  = (rx == e);
            m_sum[i] = e;
            if (rx != e && m_cnt[i] < cmax_of(i)) m_cnt[i]++;
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        exp_done = 1'b0;
        m_ok     = '0;
        for (int i = 0; i < 4; i++) begin
            m_sum[i] = '0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] busy_exp;
        busy_exp = {4{m_bits.size() != 0}};
        check_eq("busy", {28'd0, busy}, {28'd0, busy_exp});
        if (exp_done) begin
            check_eq("done", {28'd0, done}, 32'hF);
            check_eq("ok", {28'd0, ok}, {28'd0, m_ok});
            check_eq("err", {28'd0, err}, {28'd0, ~m_ok});
        end else begin
            check_eq("no_done", {28'd0, done}, 32'd0);
            check_eq("no_okerr", {24'd0, ok, err}, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("sum%0d", i), {24'd0, sum[i]}, {24'd0, m_sum[i]});
            check_eq($sformatf("cnt%0d", i), {16'd0, cnt[i]}, m_cnt[i]);
        end
        check_eq("sum3", {24'd0, sum[3]}, {24'd0, m_sum[3]});
        check_eq("cnt3", {30'd0, cnt3}, m_cnt[3]);
        if (done[0]) done_t.push_back(cycle);
        if (ok[0]) ok0_seen++;
    endtask

    // One clock: check what the previous edge produced, then drive the next inputs.
    task automatic tick(input logic e, input logic d, input logic c);
        @(negedge clk);
        check_outputs();
        en       = e;
        din      = d;
        clr      = c;
        exp_done = 1'b0;
        if (c) begin
            m_bits.delete();
        end else if (e) begin
            m_bits.push_back(d);
            if (m_bits.size() == FRAME_BITS) begin
                model_frame();
                exp_done = 1'b1;
                m_bits.delete();
            end
        end
    endtask

    function automatic logic f_bit(input int b);
        logic [WORD_W-1:0] w;
        if (b < N_WORDS * WORD_W) begin
            w = f_words[b / WORD_W];
            return w[b % WORD_W];
        end
        w = f_csum;
        return w[b - N_WORDS * WORD_W];
    endfunction

    task automatic send_bits(input int n_bits, input int gap_at, input int gap_len,
                             input int gap_pct);
        for (int b = 0; b < n_bits; b++) begin
            if (b == gap_at) repeat (gap_len) tick(1'b0, 1'($urandom), 1'b0);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct)
                repeat ($urandom_range(1, 3)) tick(1'b0, 1'($urandom), 1'b0);
            tick(1'b1, f_bit(b), 1'b0);
        end
    endtask

    task automatic load_base();
        f_words[0] = 8'h13; f_words[1] = 8'h60; f_words[2] = 8'h60; f_words[3] = 8'hD0;
        f_words[4] = 8'h2E; f_words[5] = 8'h1E; f_words[6] = 8'hDF; f_words[7] = 8'h60;
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        en  = 1'b0;
        clr = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_async", {28'd0, busy | done | ok | err}, 32'd0);
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ok_mark;
        int cnt_mark;
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        clr   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Reference frame, MODE 0 checksum.
        load_base();
        f_csum = 8'hCE;
        send_bits(FRAME_BITS, -1, 0, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("t1_sum", {24'd0, sum[0]}, 32'hCE);
        check_eq("t1_ok", ok0_seen, 1);
        check_eq("t1_cnt", {16'd0, cnt[0]}, 0);

        // Corrupted first word.
        f_words[0] = 8'h12;
        send_bits(FRAME_BITS, -1, 0, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("t2_sum", {24'd0, sum[0]}, 32'hCF);
        check_eq("t2_cnt", {16'd0, cnt[0]}, 1);

        // MODE 1 / MODE 2 reference checksums.
        load_base();
        f_csum = 8'hD2;
        send_bits(FRAME_BITS, -1, 0, 0);
        f_csum = 8'h4C;
        send_bits(FRAME_BITS, -1, 0, 0);
        f_csum = 8'h4D;
        send_bits(FRAME_BITS, -1, 0, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("t3_sum1", {24'd0, sum[1]}, 32'hD2);
        check_eq("t3_sum2", {24'd0, sum[2]}, 32'h4C);

        // Back-to-back frames with no dead cycle.
        done_t.delete();
        f_csum = 8'hCE;
        send_bits(FRAME_BITS, -1, 0, 0);
        send_bits(FRAME_BITS, -1, 0, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("t4_npulse", done_t.size(), 2);
        if (done_t.size() == 2) check_eq("t4_spacing", 32'(done_t[1] - done_t[0]), 72);

        // Enable gap mid word 3, then a frame aborted at bit 40.
        ok_mark = ok0_seen;
        send_bits(FRAME_BITS, 2 * WORD_W + 4, 5, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("t5_gap_ok", ok0_seen - ok_mark, 1);
        ok_mark = ok0_seen;
        send_bits(40, -1, 0, 0);
        tick(1'b1, 1'b1, 1'b1);
        send_bits(FRAME_BITS, -1, 0, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("t5_clr_ok", ok0_seen - ok_mark, 1);

        // clear_i while idle must not disturb anything.
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        // Reset mid-frame, then a clean frame.
        send_bits(30, -1, 0, 0);
        do_reset();
        ok_mark = ok0_seen;
        send_bits(FRAME_BITS, -1, 0, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("t6_ok", ok0_seen - ok_mark, 1);
        check_eq("t6_sum", {24'd0, sum[0]}, 32'hCE);

        // Five bad frames saturate the 2-bit counter.
        cnt_mark = int'(cnt[0]);
        f_csum = 8'h00;
        repeat (5) send_bits(FRAME_BITS, -1, 0, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("t6_sat", {30'd0, cnt3}, 3);
        check_eq("t6_cnt16", {16'd0, cnt[0]}, cnt_mark + 5);

        // Random frames, gaps, aborts and idle clears.
        for (int n = 0; n < 60; n++) begin
            int pick;
            for (int k = 0; k < N_WORDS; k++) f_words[k] = WORD_W'($urandom);
            for (int k = 0; k < N_WORDS; k++) ck_words[k] = f_words[k];
            pick = $urandom_range(3);
            f_csum = (pick < 3) ? ref_ck(pick) : WORD_W'($urandom);
            if ($urandom_range(9) == 0) begin
                send_bits($urandom_range(1, FRAME_BITS - 1), -1, 0, 10);
                tick(1'($urandom), 1'($urandom), 1'b1);
            end
            send_bits(FRAME_BITS, -1, 0, 10);
            if ($urandom_range(3) == 0) tick(1'($urandom), 1'($urandom), 1'b1);
        end
        repeat (2) tick(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
